gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the A2P core, successor to the fixed 32x32, 3-read/1-write GPR macro. Width, depth, read-port count and write-port count are configurable. Adds write-to-read bypass, deterministic write-port priority, a hardware clear sequence after reset, and a write-collision flag. Sits between decode (read addresses) and writeback (write ports); all read data is registered.

---
 rtl/gpr_file_mp.sv | 74 +++++++
 tb/tb_gpr_file_mp.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port register file with post-reset clear,
// write-to-read bypass, fixed write-port priority and a write-collision flag.
module gpr_file_mp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_RD         = 3,
  parameter int NUM_WR         = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
  output logic [NUM_RD*DATA_W-1:0] rd_dat,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_adr,
  input  logic [NUM_WR*DATA_W-1:0] wr_dat,
  output logic                     ready,
  output logic                     wr_collide
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t                   state;
  logic [ADDR_W-1:0]        clr_ptr;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_WR-1:0]        we;
  logic [NUM_RD*DATA_W-1:0] rd_nxt;
  logic                     collide;
  assign we = state == READY ? wr_en : '0;
  if (NUM_WR > 1) begin : g_col
    assign collide = &we[1:0] && wr_adr[0 +: ADDR_W] == wr_adr[ADDR_W +: ADDR_W];
  end else begin : g_nocol
    assign collide = 1'b0;
  end
  // Later write ports override earlier ones, giving port 1 priority on bypass too.
  always_comb begin
    rd_nxt = rd_dat;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        rd_nxt[i*DATA_W +: DATA_W] = state == CLEAR ? '0 : mem[rd_adr[i*ADDR_W +: ADDR_W]];
        for (int j = 0; j < NUM_WR; j++)
          if (BYPASS != 0 && we[j] && wr_adr[j*ADDR_W +: ADDR_W] == rd_adr[i*ADDR_W +: ADDR_W])
            rd_nxt[i*DATA_W +: DATA_W] = wr_dat[j*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset && state == CLEAR)
      mem[clr_ptr] <= '0;
    else
      for (int j = 0; j < NUM_WR; j++)
        if (we[j]) mem[wr_adr[j*ADDR_W +: ADDR_W]] <= wr_dat[j*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      ready      <= CLEAR_ON_RESET == 0;
      clr_ptr    <= '0;
      rd_dat     <= '0;
      wr_collide <= 1'b0;
    end else begin
      rd_dat     <= rd_nxt;
      wr_collide <= collide;
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (&clr_ptr) begin
          state <= READY;
          ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: drives a write-first and a read-first instance with identical
// stimulus and checks both against a reference register-file model.
module tb_gpr_file_mp;
  logic        clk = 0;
  logic        reset;
  logic [2:0]  rd_en;
  logic [14:0] rd_adr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_adr;
  logic [63:0] wr_dat;
  logic [95:0] rd_dat_a, rd_dat_b;
  logic        ready_a, ready_b, col_a, col_b;
  int          compared = 0;
  int          mismatched = 0;
  typedef struct {logic [95:0] a; logic [95:0] b; logic rdy; logic col;} exp_t;
  exp_t        q[$];
  logic [31:0] mem_m [32];
  logic [31:0] ra_m [3];
  logic [31:0] rb_m [3];
  logic        rdy_m, col_m;
  int          clr_m;
  always #5 clk = ~clk;
  gpr_file_mp #(.NUM_WR(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat_a),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .ready(ready_a), .wr_collide(col_a)
  );
  gpr_file_mp #(.NUM_WR(2), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat_b),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .ready(ready_b), .wr_collide(col_b)
  );
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input exp_t e);
    chk("rd_dat_bypass", rd_dat_a, e.a);
    chk("rd_dat_readfirst", rd_dat_b, e.b);
    chk("ready_a", 96'(ready_a), 96'(e.rdy));
    chk("ready_b", 96'(ready_b), 96'(e.rdy));
    chk("collide_a", 96'(col_a), 96'(e.col));
    chk("collide_b", 96'(col_b), 96'(e.col));
  endtask
  // Predict the effect of the coming edge, queue it, then compare after the edge.
  task automatic step();
    exp_t e;
    logic [4:0] a;
    if (!rdy_m) begin
      for (int p = 0; p < 3; p++) if (rd_en[p]) begin ra_m[p] = '0; rb_m[p] = '0; end
      mem_m[clr_m] = '0;
      clr_m++;
      if (clr_m == 32) rdy_m = 1'b1;
      col_m = 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (rd_en[p]) begin
          a = rd_adr[p*5 +: 5];
          rb_m[p] = mem_m[a];
          ra_m[p] = mem_m[a];
          if (wr_en[0] && wr_adr[4:0] == a) ra_m[p] = wr_dat[31:0];
          if (wr_en[1] && wr_adr[9:5] == a) ra_m[p] = wr_dat[63:32];
        end
      end
      col_m = wr_en == 2'b11 && wr_adr[4:0] == wr_adr[9:5];
      if (wr_en[0]) mem_m[wr_adr[4:0]] = wr_dat[31:0];
      if (wr_en[1]) mem_m[wr_adr[9:5]] = wr_dat[63:32];
    end
    e.a = {ra_m[2], ra_m[1], ra_m[0]};
    e.b = {rb_m[2], rb_m[1], rb_m[0]};
    e.rdy = rdy_m;
    e.col = col_m;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_all(q.pop_front());
  endtask
  task automatic do_reset();
    exp_t e;
    reset = 1'b0;
    #1;
    q.delete();
    rdy_m = 1'b0;
    clr_m = 0;
    col_m = 1'b0;
    for (int p = 0; p < 3; p++) begin ra_m[p] = '0; rb_m[p] = '0; end
    e.a = '0;
    e.b = '0;
    e.rdy = 1'b0;
    e.col = 1'b0;
    check_all(e);
  endtask
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  task automatic clear_steps(input int n);
    for (int k = 0; k < n; k++) begin
      wr_en  = 2'b11;
      wr_adr = {5'($urandom_range(31)), 5'($urandom_range(31))};
      wr_dat = {$urandom, $urandom};
      rd_en  = 3'($urandom);
      rd_adr = 15'($urandom);
      step();
    end
    wr_en = '0;
  endtask
  task automatic read_all();
    rd_en = 3'b111;
    for (int k = 0; k < 32; k += 3) begin
      rd_adr = {5'(k + 2), 5'(k + 1), 5'(k)};
      step();
    end
  endtask
  initial begin
    reset = 1'b1; rd_en = '0; rd_adr = '0; wr_en = '0; wr_adr = '0; wr_dat = '0;
    #2;
    do_reset();
    release_reset();
    clear_steps(32);
    read_all();
    wr_en = 2'b01; wr_adr = 10'd7; wr_dat = {32'h0, 32'hDEADBEEF}; rd_en = 3'b000;
    step();
    wr_en = 2'b00; rd_en = 3'b111; rd_adr = {5'd7, 5'd7, 5'd7};
    step();
    wr_en = 2'b01; wr_adr = 10'd3; wr_dat = {32'h0, 32'h12345678};
    rd_en = 3'b010; rd_adr = {5'd7, 5'd3, 5'd7};
    step();
    wr_en = 2'b00;
    step();
    wr_en = 2'b11; wr_adr = {5'd9, 5'd9}; wr_dat = {32'h5555FFFF, 32'hAAAA0000};
    rd_en = 3'b001; rd_adr = {5'd7, 5'd3, 5'd9};
    step();
    wr_en = 2'b00; rd_en = 3'b111; rd_adr = {5'd9, 5'd9, 5'd9};
    step();
    step();
    rd_en = 3'b011; rd_adr = {5'd7, 5'd3, 5'd3};
    step();
    step();
    rd_en = 3'b111;
    step();
    for (int k = 0; k < 60; k++) begin
      rd_en  = 3'($urandom);
      rd_adr = {5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7))};
      wr_en  = 2'($urandom);
      wr_adr = {5'($urandom_range(7)), 5'($urandom_range(7))};
      wr_dat = {$urandom, $urandom};
      step();
    end
    wr_en = 2'b11; wr_adr = {5'd4, 5'd5}; wr_dat = {$urandom, $urandom}; rd_en = 3'b111;
    step();
    #3;
    do_reset();
    release_reset();
    clear_steps(10);
    #3;
    do_reset();
    release_reset();
    clear_steps(32);
    read_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
